// File: rtl/sqrt_metrics_pkg.sv
// Shared definitions for the square-root error-metrics block: default widths
// and the run-control state encoding.
package sqrt_metrics_pkg;

    localparam int DEF_OUT_W  = 8;
    localparam int DEF_CNT_W  = 17;
    localparam int DEF_FRAC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/sqrt_metrics_div.sv
// Iterative restoring divider. It produces one quotient bit per cycle and
// exposes the final quotient combinationally during its last iteration.
module sqrt_metrics_div #(
    parameter int DIVISOR_W  = 8,
    parameter int DIVIDEND_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  q_valid,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int STEP_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    logic                  busy_q, busy_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;

    logic [DIVISOR_W:0]    shifted;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic                  last_step;

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        shifted   = {rem_q, quo_q[DIVIDEND_W-1]};
        fits      = shifted >= {1'b0, divisor_q};
        rem_next  = fits ? DIVISOR_W'(shifted - {1'b0, divisor_q}) : shifted[DIVISOR_W-1:0];
        quo_next  = {quo_q[DIVIDEND_W-2:0], fits};
        last_step = busy_q && (step_q == STEP_W'(DIVIDEND_W - 1));
    end

    always_comb begin
        busy_d    = busy_q;
        step_d    = step_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        if (clear) begin
            busy_d    = 1'b0;
            step_d    = '0;
            rem_d     = '0;
            quo_d     = '0;
            divisor_d = '0;
        end else if (load) begin
            busy_d    = 1'b1;
            step_d    = '0;
            rem_d     = '0;
            quo_d     = dividend;
            divisor_d = divisor;
        end else if (busy_q) begin
            rem_d  = rem_next;
            quo_d  = quo_next;
            step_d = step_q + STEP_W'(1);
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            step_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else begin
            busy_q    <= busy_d;
            step_q    <= step_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
        end
    end

    assign busy     = busy_q;
    assign q_valid  = last_step;
    assign quotient = quo_next;

endmodule

// File: rtl/sqrt_err_metrics.sv
// Accumulates error-distance statistics (count, sum, max, relative-error sum)
// between an approximate and an exact square-root over a run of samples.
module sqrt_err_metrics
    import sqrt_metrics_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_samples,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OUT_W-1:0]              approx,
    input  logic [OUT_W-1:0]              exact,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              sample_count,
    output logic [CNT_W-1:0]              err_count,
    output logic [OUT_W+CNT_W-1:0]        ed_sum,
    output logic [OUT_W-1:0]              ed_max,
    output logic [OUT_W+FRAC_W+CNT_W-1:0] red_sum
);

    localparam int DIV_W = OUT_W + FRAC_W;
    localparam int ED_W  = OUT_W + CNT_W;
    localparam int RED_W = OUT_W + FRAC_W + CNT_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  sample_count_q, sample_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [ED_W-1:0]   ed_sum_q, ed_sum_d;
    logic [OUT_W-1:0]  ed_max_q, ed_max_d;
    logic [RED_W-1:0]  red_sum_q, red_sum_d;

    logic [OUT_W-1:0]  abs_diff;
    logic              transfer;
    logic              needs_div;
    logic              last_pair;
    logic              div_busy;
    logic              div_q_valid;
    logic              div_done;
    logic [DIV_W-1:0]  div_quotient;

    // start wins over a simultaneous transfer, so a restarting run never counts that pair.
    always_comb begin
        abs_diff  = (approx >= exact) ? (approx - exact) : (exact - approx);
        transfer  = in_valid && (state_q == ST_ACCEPT) && !start;
        needs_div = (abs_diff != '0) && (exact != '0);
        last_pair = (sample_count_q + CNT_W'(1)) == target_q;
        div_done  = (state_q == ST_DIVIDE) && div_busy && div_q_valid;
    end

    sqrt_metrics_div #(
        .DIVISOR_W  (OUT_W),
        .DIVIDEND_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .load     (transfer && needs_div),
        .dividend ({abs_diff, {FRAC_W{1'b0}}}),
        .divisor  (exact),
        .busy     (div_busy),
        .q_valid  (div_q_valid),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (num_samples == '0) ? ST_DONE : ST_ACCEPT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ACCEPT: begin
                    if (transfer) begin
                        if (needs_div) begin
                            state_d = ST_DIVIDE;
                        end else begin
                            state_d = last_pair ? ST_DONE : ST_ACCEPT;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        state_d = (sample_count_q == target_q) ? ST_DONE : ST_ACCEPT;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == ST_ACCEPT);
        busy     = (state_q == ST_ACCEPT) || (state_q == ST_DIVIDE);
        done     = (state_q == ST_DONE);
    end

    // The sample is counted at transfer time; its relative-error term lands when the divider finishes.
    always_comb begin
        target_d       = target_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        ed_sum_d       = ed_sum_q;
        ed_max_d       = ed_max_q;
        red_sum_d      = red_sum_q;
        if (start) begin
            target_d       = num_samples;
            sample_count_d = '0;
            err_count_d    = '0;
            ed_sum_d       = '0;
            ed_max_d       = '0;
            red_sum_d      = '0;
        end else if (transfer) begin
            sample_count_d = sample_count_q + CNT_W'(1);
            if (abs_diff != '0) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            ed_sum_d = ed_sum_q + ED_W'(abs_diff);
            ed_max_d = (abs_diff > ed_max_q) ? abs_diff : ed_max_q;
        end else if (div_done) begin
            red_sum_d = red_sum_q + RED_W'(div_quotient);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q       <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            ed_sum_q       <= '0;
            ed_max_q       <= '0;
            red_sum_q      <= '0;
        end else begin
            target_q       <= target_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            ed_sum_q       <= ed_sum_d;
            ed_max_q       <= ed_max_d;
            red_sum_q      <= red_sum_d;
        end
    end

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign ed_sum       = ed_sum_q;
    assign ed_max       = ed_max_q;
    assign red_sum      = red_sum_q;

endmodule

// File: doc/sqrt_err_metrics.md
SQRT_ERR_METRICS -- requirements
Module: sqrt_err_metrics

Interface
REQ-001 Parameter OUT_W, default 8, width of the approximate and exact square-root results.
REQ-002 Parameter CNT_W, default 17, width of the sample counters; 65536 samples fit.
REQ-003 Parameter FRAC_W, default 16, fractional bits of each relative-error term.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; clears all accumulators, latches num_samples, begins a run.
REQ-007 num_samples  input  CNT_W  number of (approx, exact) pairs in the run; sampled only on start.
REQ-008 in_valid  input  1  approx/exact pair present.
REQ-009 in_ready  output  1  block accepts a pair this cycle.
REQ-010 approx  input  OUT_W  approximate square-root output under test.
REQ-011 exact  input  OUT_W  reference floor(sqrt) value.
REQ-012 busy  output  1  run in progress (ACCEPT or DIVIDE).
REQ-013 done  output  1  run complete; held high until next start.
REQ-014 sample_count  output  CNT_W  pairs accepted this run.
REQ-015 err_count  output  CNT_W  pairs with approx != exact.
REQ-016 ed_sum  output  OUT_W+CNT_W  sum of |approx-exact| (NMED numerator).
REQ-017 ed_max  output  OUT_W  maximum |approx-exact| (EDmax).
REQ-018 red_sum  output  OUT_W+FRAC_W+CNT_W  sum of floor((|approx-exact| << FRAC_W) / exact) (MRED numerator).

Function
REQ-019 States: IDLE, ACCEPT, DIVIDE, DONE.
REQ-020 IDLE/DONE/ACCEPT/DIVIDE + start: clear all counters and sums, load num_samples; go to DONE if num_samples==0, else ACCEPT, next cycle.
REQ-021 start overrides any simultaneous transfer; a run in progress is aborted and restarted.
REQ-022 in_ready = 1 only in ACCEPT; transfer occurs when in_valid && in_ready.
REQ-023 On transfer: abs = |approx-exact| (OUT_W bits, no wrap); sample_count+1; err_count+1 if abs!=0; ed_sum+=abs; ed_max=max(ed_max,abs); all updated the following cycle.
REQ-024 Transfer with abs==0 or exact==0: red_sum unchanged, no DIVIDE; pair costs one cycle.
REQ-025 Transfer with abs!=0 and exact!=0: enter DIVIDE; restoring division of (abs << FRAC_W) by exact, one quotient bit per cycle, OUT_W+FRAC_W cycles; quotient added to red_sum on the last cycle; in_ready low throughout.
REQ-026 After the pair that makes sample_count equal num_samples (including its division), go to DONE; done=1, busy=0.
REQ-027 Otherwise return to ACCEPT after the pair or its division.
REQ-028 DONE holds all result outputs stable until start.
REQ-029 Accumulator widths are sized so no overflow occurs for any num_samples < 2^CNT_W; no saturation logic.

Reset
REQ-030 rst_n low: state IDLE; in_ready, busy, done = 0; sample_count, err_count, ed_sum, ed_max, red_sum = 0; divider cleared.
REQ-031 Reset asserted mid-division or mid-run discards all partial results; no run resumes after release.
REQ-032 First start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package sqrt_metrics_pkg holds the state enumeration and default OUT_W/CNT_W/FRAC_W constants.
REQ-034 Sub-module sqrt_metrics_div implements the iterative restoring divider (load, busy, valid quotient); the top holds FSM and accumulators.

Verification
REQ-035 Reset then start, num_samples=0 -> done=1 next cycle, all results 0, in_ready never high.
REQ-036 num_samples=3, pairs (4,4),(5,4),(2,3) -> err_count=2, ed_sum=2, ed_max=1, red_sum=16384+21845=38229, done=1.
REQ-037 Pair (7,0) -> err_count=1, ed_sum=7, ed_max=7, red_sum=0, pair accepted in one cycle.
REQ-038 Pair (0,255) -> in_ready low exactly 24 cycles after transfer, red_sum=65536.
REQ-039 start asserted during DIVIDE -> all outputs 0 next cycle, new run counts only subsequent pairs.
REQ-040 rst_n pulsed low during ACCEPT with in_valid held high -> outputs 0 immediately, in_ready stays 0 until a new start.
